ser_tx_multi: RTL
=================

Name: ser_tx_multi

Overview:
- Parametrised parallel-in/serial-out transmitter.
- CHANNELS independent WIDTH-bit holding registers are loaded in parallel and then sent as one serial frame, channel 0 first, one bit per clock.
- Adds three things to the fixed 4x4-bit serializer: a synchronous start, a selectable bit order, and an optional frame parity bit.
- Sits between the register-load logic and the serial line driver, and raises busy/done for the sequencing controller.

Parameters:
- WIDTH, 4: bits per channel register (>=1).
- CHANNELS, 4: number of channel registers (>=1).
- MSB_FIRST, 0: 0 = bit 0 of each channel sent first; 1 = bit WIDTH-1 sent first.
- PARITY_EN, 0: 1 = append one parity bit after the last data bit.
- PARITY_ODD, 0: 0 = even parity; 1 = odd parity. Ignored when PARITY_EN=0.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr_n  in  1  asynchronous active-low reset.
- din  in  WIDTH*CHANNELS  parallel data; channel i occupies din[i*WIDTH +: WIDTH].
- ld  in  CHANNELS  per-channel load strobe; ld[i] loads channel i.
- transmit  in  1  frame start request, sampled on clk.
- tx_data  out  1  serial data bit.
- tx_valid  out  1  high while tx_data carries a data bit or the parity bit.
- TC  out  1  high during the last data bit of the frame.
- bit_idx  out  max(1,$clog2(WIDTH))  current bit counter.
- word_idx  out  max(1,$clog2(CHANNELS))  current channel counter.
- busy  out  1  high in SHIFT and PARITY.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (clr_n=0, asynchronous): FSM goes to IDLE. All channel registers, bit_idx, word_idx, tx_data, tx_valid, TC, busy and done go to 0. A frame in progress is aborted with no done pulse.
- States: IDLE, SHIFT, PARITY, DONE.
- IDLE:
  - ld[i]=1 loads channel i from its din slice on the next edge.
  - transmit=1 moves to SHIFT on the next edge with bit_idx=0, word_idx=0. Latency is 1 clock from transmit to the first valid bit.
  - ld and transmit high in the same cycle: the load lands first, so the frame carries the new data.
- SHIFT:
  - tx_valid=1.
  - tx_data = chan[word_idx][bit_idx] when MSB_FIRST=0; chan[word_idx][WIDTH-1-bit_idx] when MSB_FIRST=1.
  - bit_idx increments each clock. At WIDTH-1 it wraps to 0 and word_idx increments.
  - TC=1 when bit_idx==WIDTH-1 and word_idx==CHANNELS-1.
  - On the TC cycle: go to PARITY if PARITY_EN=1, otherwise to DONE. Counters return to 0.
- PARITY (one cycle):
  - tx_valid=1, TC=0.
  - tx_data = XOR of all WIDTH*CHANNELS register bits, inverted when PARITY_ODD=1.
- DONE (one cycle): done=1, busy=0, tx_valid=0. Next state is IDLE.
- Outside SHIFT and PARITY: tx_data=0 and tx_valid=0.
- Transmission is non-destructive (index-selected, not shifted). Registers keep their contents after a frame, so a second transmit resends identical data.
- ld during SHIFT, PARITY or DONE is ignored; registers stay frozen for the whole frame.
- transmit outside IDLE is ignored.
- transmit held high: back-to-back frames, separated by exactly one DONE cycle and one IDLE cycle.
- Frame length is WIDTH*CHANNELS + PARITY_EN valid cycles.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

Test Plan:
- Defaults. Load A=4'h1, B=4'h2, C=4'h4, D=4'h8 via ld=4'b1111, then pulse transmit. Required: 16 valid cycles, tx_data = 1000_0100_0010_0001 in time order, TC on cycle 16, done one cycle later.
- MSB_FIRST=1, same data. Required: tx_data = 0001_0010_0100_1000.
- PARITY_EN=1, data 4'h7,0,0,0. Required: 17th valid bit = 1 for even parity; 0 with PARITY_ODD=1.
- WIDTH=8, CHANNELS=3, data 8'hA5, 8'h3C, 8'hFF. Required: 24 valid bits, LSB-first per channel; word_idx sequence 0,1,2.
- Mid-frame: assert ld with new data at bit 5. Required: data unchanged. Then drop clr_n at bit 9. Required: all outputs 0 immediately, no done pulse, registers 0.
- transmit held high for 40 cycles (defaults). Required: two identical frames, each followed by DONE then IDLE. Also ld and transmit in the same IDLE cycle: required frame carries the new data.

Source files
------------

// File: rtl/ser_tx_multi.sv
// ser_tx_multi: parametrised parallel-in/serial-out frame transmitter.
// CHANNELS holding registers of WIDTH bits are loaded in parallel while idle,
// then sent as one frame (channel 0 first), optionally followed by a parity bit.
// Bits are picked by index rather than shifted out, so the registers keep
// their contents and a second start resends the same frame.
module ser_tx_multi #(
  parameter int WIDTH      = 4,
  parameter int CHANNELS   = 4,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         clr_n,
  input  logic [WIDTH*CHANNELS-1:0]    din,
  input  logic [CHANNELS-1:0]          ld,
  input  logic                         transmit,
  output logic                         tx_data,
  output logic                         tx_valid,
  output logic                         TC,
  output logic [BW-1:0]                bit_idx,
  output logic [CW-1:0]                word_idx,
  output logic                         busy,
  output logic                         done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(CHANNELS - 1);

  // Frame parity over every register bit; odd parity inverts the XOR.
  function automatic logic calc_parity(input logic [WIDTH*CHANNELS-1:0] v);
    logic odd_s;
    odd_s = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
    return (^v) ^ odd_s;
  endfunction

  logic [1:0]                  state_q, state_d;
  logic [BW-1:0]               bit_idx_q, bit_idx_d;
  logic [CW-1:0]               word_idx_q, word_idx_d;
  logic [WIDTH*CHANNELS-1:0]   chan_q, chan_d;

  logic                        last_bit_s;
  logic                        last_word_s;
  logic [WIDTH-1:0]            cur_chan_s;
  logic                        cur_bit_s;

  assign last_bit_s  = (bit_idx_q == LAST_BIT);
  assign last_word_s = (word_idx_q == LAST_WORD);

  // Select the channel addressed by word_idx and the bit addressed by bit_idx.
  always_comb begin
    cur_chan_s = {WIDTH{1'b0}};
    cur_bit_s  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (word_idx_q == CW'(i)) begin
        cur_chan_s = chan_q[i*WIDTH +: WIDTH];
      end else begin
        cur_chan_s = cur_chan_s;
      end
    end
    for (int b = 0; b < WIDTH; b++) begin
      if (bit_idx_q == BW'(b)) begin
        cur_bit_s = (MSB_FIRST != 0) ? cur_chan_s[WIDTH-1-b] : cur_chan_s[b];
      end else begin
        cur_bit_s = cur_bit_s;
      end
    end
  end

  // Next-state, counter and register-load logic.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    word_idx_d = word_idx_q;
    chan_d     = chan_q;
    case (state_q)
      S_IDLE: begin
        // Loads land on the same edge that starts a frame, so the frame
        // carries freshly loaded data.
        for (int i = 0; i < CHANNELS; i++) begin
          if (ld[i]) begin
            chan_d[i*WIDTH +: WIDTH] = din[i*WIDTH +: WIDTH];
          end else begin
            chan_d[i*WIDTH +: WIDTH] = chan_q[i*WIDTH +: WIDTH];
          end
        end
        if (transmit) begin
          state_d    = S_SHIFT;
          bit_idx_d  = {BW{1'b0}};
          word_idx_d = {CW{1'b0}};
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (last_bit_s) begin
          bit_idx_d = {BW{1'b0}};
          if (last_word_s) begin
            word_idx_d = {CW{1'b0}};
            state_d    = (PARITY_EN != 0) ? S_PARITY : S_DONE;
          end else begin
            word_idx_d = word_idx_q + CW'(1);
          end
        end else begin
          bit_idx_d = bit_idx_q + BW'(1);
        end
      end
      S_PARITY: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        bit_idx_d  = {BW{1'b0}};
        word_idx_d = {CW{1'b0}};
      end
    endcase
  end

  // State, counters and channel registers; reset aborts any frame.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_IDLE;
      bit_idx_q  <= {BW{1'b0}};
      word_idx_q <= {CW{1'b0}};
      chan_q     <= {(WIDTH*CHANNELS){1'b0}};
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      word_idx_q <= word_idx_d;
      chan_q     <= chan_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    tx_data  = 1'b0;
    tx_valid = 1'b0;
    TC       = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_SHIFT: begin
        tx_data  = cur_bit_s;
        tx_valid = 1'b1;
        TC       = last_bit_s & last_word_s;
        busy     = 1'b1;
      end
      S_PARITY: begin
        tx_data  = calc_parity(chan_q);
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        tx_data  = 1'b0;
        tx_valid = 1'b0;
      end
    endcase
  end

  assign bit_idx  = bit_idx_q;
  assign word_idx = word_idx_q;

endmodule
